systolic_skew_feeder: RTL and testbench
=======================================

// Module: systolic_skew_feeder
// PURPOSE
//  Operand feeder that sits directly upstream of a row of PE lanes in the systolic array.
//  Accepts one N-wide vector of 16-bit operands per beat through a val/rdy handshake.
//  Re-times the vector into a diagonal wavefront: lane i sees the element i cycles after lane 0.
//  Flushes the wavefront at tile end and pulses tile_done, so downstream accumulators can be cleared.
// PARAMETERS
//  N      4   number of PE lanes fed (>=2)
//  DW     16  operand width per lane; matches the PE data_in_a/data_in_b width
// PORTS
//  clk        in   1     rising-edge clock; single clock domain
//  reset      in   1     asynchronous, active-low reset
//  in_data    in   N*DW  operand vector; lane i = in_data[i*DW +: DW]
//  in_val     in   1     in_data/in_last valid
//  in_last    in   1     marks final beat of a tile
//  in_rdy     out  1     feeder can accept a beat this cycle
//  out_data   out  N*DW  skewed operands to PE lanes (lane i slice as for in_data)
//  out_val    out  N     per-lane valid to PE val_in
//  out_rdy    in   1     array ready (PE rdy chain); 0 = global stall
//  busy       out  1     a tile is in flight (state != IDLE)
//  tile_done  out  1     1-cycle pulse: last element of tile left lane N-1
// BEHAVIOUR
//  Reset (reset=0, async): every delay-line register = 0, all out_val = 0, out_data = 0.
//   Also: state = IDLE, tile_done = 0, busy = 0.
//  Advance: adv = out_rdy. When adv=0, every register holds; outputs are stable (stall).
//  Accept: acc = in_val & in_rdy. Combinational in_rdy = out_rdy & (state != DRAIN).
//  Lane i is a delay line of i+1 registers of {val, data}; lane N-1 also carries a last flag.
//  On adv, stage 0 of every lane loads:
//   - if acc: val=1, data = slice, last = in_last;
//   - otherwise: bubble (val=0, data=0, last=0).
//   Subsequent stages shift.
//  Latency: lane i output = beat accepted at cycle t appears at t+1+i, counting advancing cycles only.
//  Bubbles always carry data=0, so a PE that ignores val still accumulates 0.
//  FSM (updates only on adv, except reset):
//   IDLE   -> STREAM on acc & !in_last; -> DRAIN on acc & in_last (single-beat tile).
//   STREAM -> DRAIN on acc & in_last; otherwise stays in STREAM (gaps in in_val are legal and produce bubbles).
//   DRAIN  -> IDLE when drain counter reaches N-1 advancing cycles after entry; no accepts while in DRAIN.
//   Drain counter width = clog2(N); clears on entry to DRAIN.
//  tile_done = 1 for exactly one cycle when lane N-1 output stage holds val=1 & last=1 and adv=1.
//   It is asserted coincident with that element being consumed.
//  Boundary conditions:
//   - in_val=1 with out_rdy=0: no accept, no state change.
//   - Stall during DRAIN: the counter freezes.
//   - Back-to-back tiles: the next tile's first beat is accepted the cycle after DRAIN -> IDLE.
//     Minimum gap is N-1 cycles, so the two tiles' wavefronts never overlap.
//   - in_last with in_val=0: ignored.
//   - Reset asserted mid-tile: all in-flight data discarded, no tile_done.
//  Width rules: data passes through unmodified; no arithmetic on operands.
// STRUCTURE
//  Shared package (pe_array_pkg): DW default, lane count N, typedef lane_t = logic [DW-1:0].
//   Also the FSM state enum feeder_state_e {IDLE, STREAM, DRAIN}.
//  One sub-module: skew_delay_line #(DEPTH, W): DEPTH-stage shift register with enable and async active-low clear.
//   Instantiated per lane via generate, with DEPTH = i+1.
//  FSM, drain counter, and tile_done logic live in the top module.
// TESTING (N=4, DW=16)
//  1. Reset: drive reset=0 mid-stream with lanes full -> next edge all out_val=0, out_data=0, busy=0, tile_done=0.
//  2. Single beat in_data={4,3,2,1}, in_last=1, out_rdy=1:
//     -> lane0=1 at t+1, lane1=2 at t+2, lane2=3 at t+3, lane3=4 at t+4.
//     -> tile_done at t+4; in_rdy low t+1..t+3; busy low at t+4.
//  3. Three-beat tile of beats A,B,C, back-to-back:
//     -> lane3 emits A,B,C at t+4..t+6 with val=1; tile_done only with C.
//     -> lane0 val=0 and data=0 from t+4.
//  4. Stall: hold out_rdy=0 for 5 cycles after the second beat of a tile.
//     -> all outputs frozen; in_rdy=0; no beats lost or duplicated.
//     -> after release, the per-lane sequence matches the unstalled run shifted by 5 cycles.
//  5. Gapped input: in_val pattern 1,0,1 (last on the 2nd valid beat).
//     -> a bubble with val=0, data=0 appears between the two elements on every lane.
//     -> tile_done follows lane3's last element.
//  6. Next tile offered during DRAIN -> not accepted until IDLE; first new-tile element is never mixed into old-tile outputs.

Source files
------------

// File: rtl/pe_array_pkg.sv
// Shared definitions for the PE array operand path.
//   DW_DEFAULT     : default operand width per lane
//   N_DEFAULT      : default number of PE lanes
//   lane_t         : one lane operand at the default width
//   feeder_state_e : skew feeder tile FSM states
package pe_array_pkg;

  localparam int DW_DEFAULT = 16;
  localparam int N_DEFAULT  = 4;

  typedef logic [DW_DEFAULT-1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } feeder_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage shift register with a common enable and asynchronous clear.
// One instance per feeder lane; the depth sets that lane's skew.
//   clk   : rising-edge clock
//   reset : asynchronous active-low clear of every stage
//   en    : shift enable (all stages hold when low)
//   d     : word loaded into stage 0
//   q     : word held in the last stage
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_p [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) stage_p[k] <= '0;
    end else if (en) begin
      stage_p[0] <= d;
      for (int k = 1; k < DEPTH; k++) stage_p[k] <= stage_p[k-1];
    end
  end

  assign q = stage_p[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Operand feeder for a row of PE lanes. Accepts one N-wide operand vector
// per beat and re-times it into a diagonal wavefront (lane i lags lane 0 by
// i advancing cycles). At tile end the wavefront is drained and tile_done
// pulses as the last element leaves lane N-1.
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   in_data   : operand vector, lane i = in_data[i*DW +: DW]
//   in_val    : in_data/in_last valid
//   in_last   : final beat of a tile
//   in_rdy    : beat can be accepted this cycle
//   out_data  : skewed operands, same lane slicing as in_data
//   out_val   : per-lane valid
//   out_rdy   : array ready; low stalls the whole feeder
//   busy      : a tile is in flight
//   tile_done : one-cycle pulse as the tile's last element is consumed
module systolic_skew_feeder
  import pe_array_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N*DW-1:0] in_data,
  input  logic          in_val,
  input  logic          in_last,
  output logic          in_rdy,
  output logic [N*DW-1:0] out_data,
  output logic [N-1:0]  out_val,
  input  logic          out_rdy,
  output logic          busy,
  output logic          tile_done
);

  localparam int CW = $clog2(N);

  feeder_state_e state_q, state_d;
  logic [CW-1:0] drain_cnt_q, drain_cnt_d;
  logic          adv;
  logic          acc;
  logic          last_out;

  assign adv    = out_rdy;
  assign in_rdy = out_rdy & (state_q != DRAIN);
  assign acc    = in_val & in_rdy;

  // Stage 0 loads a beat or a zeroed bubble; bubbles carry data 0 so a PE
  // that ignores val still accumulates nothing.
  for (genvar i = 0; i < N; i++) begin : g_lane
    if (i == N-1) begin : g_tail
      logic [DW+1:0] d_p0;
      logic [DW+1:0] q_pn;
      assign d_p0 = {acc & in_last, acc, acc ? in_data[i*DW +: DW] : {DW{1'b0}}};
      skew_delay_line #(.DEPTH(i+1), .W(DW+2)) u_dl (
        .clk   (clk),
        .reset (reset),
        .en    (adv),
        .d     (d_p0),
        .q     (q_pn)
      );
      assign last_out              = q_pn[DW+1];
      assign out_val[i]            = q_pn[DW];
      assign out_data[i*DW +: DW]  = q_pn[DW-1:0];
    end else begin : g_body
      logic [DW:0] d_p0;
      logic [DW:0] q_pn;
      assign d_p0 = {acc, acc ? in_data[i*DW +: DW] : {DW{1'b0}}};
      skew_delay_line #(.DEPTH(i+1), .W(DW+1)) u_dl (
        .clk   (clk),
        .reset (reset),
        .en    (adv),
        .d     (d_p0),
        .q     (q_pn)
      );
      assign out_val[i]           = q_pn[DW];
      assign out_data[i*DW +: DW] = q_pn[DW-1:0];
    end
  end

  // Tile FSM: DRAIN lasts N-1 advancing cycles, enough for the last beat to
  // reach lane N-1, so consecutive tiles never overlap on any lane.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    if (adv) begin
      case (state_q)
        IDLE: begin
          if (acc) begin
            state_d     = in_last ? DRAIN : STREAM;
            drain_cnt_d = '0;
          end
        end
        STREAM: begin
          if (acc && in_last) begin
            state_d     = DRAIN;
            drain_cnt_d = '0;
          end
        end
        DRAIN: begin
          if (drain_cnt_q == CW'(N-2)) state_d = IDLE;
          else                          drain_cnt_d = drain_cnt_q + CW'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign tile_done = out_val[N-1] & last_out & adv;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
module tb_systolic_skew_feeder;

  localparam int N  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [N*DW-1:0] in_data;
  logic          in_val;
  logic          in_last;
  logic          in_rdy;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]  out_val;
  logic          out_rdy;
  logic          busy;
  logic          tile_done;

  systolic_skew_feeder #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_val    (in_val),
    .in_last   (in_last),
    .in_rdy    (in_rdy),
    .out_data  (out_data),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .busy      (busy),
    .tile_done (tile_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            lane;
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   td_q[$];
  int   slot;
  int   errors;
  int   checks;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus. Outputs are compared against the scoreboard
  // between edges; the model advances only on cycles with out_rdy high.
  task automatic step(input logic v, input logic l, input logic [N*DW-1:0] d,
                      input logic r, input logic exp_rdy, input logic exp_busy);
    logic [DW-1:0] ev;
    logic          evv;
    logic          etd;
    exp_t          e;
    @(negedge clk);
    in_val  = v;
    in_last = l;
    in_data = d;
    out_rdy = r;
    #1;
    check("in_rdy", in_rdy, exp_rdy);
    check("busy", busy, exp_busy);
    for (int i = 0; i < N; i++) begin
      evv = 1'b0;
      ev  = '0;
      foreach (sb[j]) if (sb[j].lane == i && sb[j].due == slot) begin
        evv = 1'b1;
        ev  = sb[j].data;
      end
      check($sformatf("lane%0d_val@%0d", i, slot), out_val[i], evv);
      check($sformatf("lane%0d_data@%0d", i, slot), out_data[i*DW +: DW], ev);
    end
    etd = r && td_q.size() > 0 && td_q[0] == slot;
    check($sformatf("tile_done@%0d", slot), tile_done, etd);
    @(posedge clk);
    if (r) begin
      for (int j = sb.size() - 1; j >= 0; j--) if (sb[j].due == slot) sb.delete(j);
      if (td_q.size() > 0 && td_q[0] == slot) void'(td_q.pop_front());
      slot++;
      if (v && exp_rdy) begin
        for (int i = 0; i < N; i++) begin
          e.lane = i;
          e.due  = slot + i;
          e.data = d[i*DW +: DW];
          sb.push_back(e);
        end
        if (l) td_q.push_back(slot + N - 1);
      end
    end
  endtask

  task automatic idle(input int n, input logic exp_busy);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, 1'b1, 1'b1, exp_busy);
  endtask

  function automatic logic [N*DW-1:0] rnd_vec();
    return {$urandom(), $urandom()};
  endfunction

  logic [N*DW-1:0] va, vb, vc, vd;

  initial begin
    errors  = 0;
    checks  = 0;
    slot    = 0;
    reset   = 1'b0;
    in_val  = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    out_rdy = 1'b1;

    // Power-on reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_val", out_val, '0);
    check("rst_out_data_lo", out_data[31:0], '0);
    check("rst_out_data_hi", out_data[63:32], '0);
    check("rst_busy", busy, 1'b0);
    check("rst_tile_done", tile_done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    idle(2, 1'b0);

    // Single-beat tile {4,3,2,1}
    va = {16'd4, 16'd3, 16'd2, 16'd1};
    step(1'b1, 1'b1, va, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b0);

    // Three-beat back-to-back tile
    va = rnd_vec(); vb = rnd_vec(); vc = rnd_vec();
    step(1'b1, 1'b0, va, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, vb, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, vc, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b0);

    // Stall for 5 cycles after the second beat, then stall inside DRAIN
    va = rnd_vec(); vb = rnd_vec(); vc = rnd_vec();
    step(1'b1, 1'b0, va, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, vb, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, vc, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, vc, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b0);

    // Gapped input 1,0,1 with a stray in_last on the gap
    va = rnd_vec(); vb = rnd_vec();
    step(1'b1, 1'b0, va, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, rnd_vec(), 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, vb, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    idle(2, 1'b0);

    // Next tile offered during DRAIN, accepted right after return to IDLE
    va = rnd_vec(); vb = rnd_vec(); vc = rnd_vec();
    step(1'b1, 1'b1, va, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, vb, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, vb, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, vc, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    idle(2, 1'b0);

    // Reset asserted mid-tile with lanes full
    va = rnd_vec(); vb = rnd_vec(); vc = rnd_vec(); vd = rnd_vec();
    step(1'b1, 1'b0, va, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, vb, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, vc, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, vd, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    in_val = 1'b0;
    in_last = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("midrst_out_val", out_val, '0);
    check("midrst_out_data_lo", out_data[31:0], '0);
    check("midrst_out_data_hi", out_data[63:32], '0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_tile_done", tile_done, 1'b0);
    sb.delete();
    td_q.delete();
    @(posedge clk);
    #1;
    check("midrst_edge_out_val", out_val, '0);
    @(negedge clk);
    reset = 1'b1;
    idle(5, 1'b0);

    check("sb_drained", sb.size(), 0);
    check("td_drained", td_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
